// File: rtl/service_1_countdown.sv
// ============================================================================
// Module   : service_1_countdown
// Purpose  : Countdown stage fed by the time-set service. Captures a BCD
//            min:sec value on load, counts down once per second under
//            start/pause control and raises an alarm at 00:00.
// Ports    : clk      - system clock, all logic on posedge
//            reset    - asynchronous active-high reset
//            load     - one-cycle capture pulse for num_in
//            num_in   - BCD time {min tens, min ones, sec tens, sec ones}
//            push_c   - one-cycle start/pause toggle / alarm acknowledge
//            num      - remaining time, same BCD layout as num_in
//            running  - high while counting
//            done     - one-cycle pulse on reaching 00:00 while counting
//            alarm    - high from reaching 00:00 until acknowledged
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module service_1_countdown #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] num_in,
    input  logic        push_c,
    output logic [15:0] num,
    output logic        running,
    output logic        done,
    output logic        alarm
);

    // A single-cycle divider still needs a 1-bit prescaler to be legal.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] c_presc_max = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] c_presc_one = PW'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PAUSED = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_ALARM  = 2'd3;

    logic [1:0]    r_state;
    logic [15:0]   r_num;
    logic [PW-1:0] r_presc;
    logic          r_running;
    logic          r_done;
    logic          r_alarm;

    logic [1:0]    w_state_nxt;
    logic [15:0]   w_num_nxt;
    logic [PW-1:0] w_presc_nxt;
    logic          w_done_nxt;
    logic [15:0]   w_load_val;
    logic [15:0]   w_dec_val;
    logic          w_tick;

    // Clamp out-of-range digits so num always holds a valid time.
    function automatic logic [15:0] sanitise(input logic [15:0] v);
        logic [3:0] m10, m1, s10, s1;
        m10 = (v[15:12] > 4'd9) ? 4'd9 : v[15:12];
        m1  = (v[11:8]  > 4'd9) ? 4'd9 : v[11:8];
        s10 = (v[7:4]   > 4'd5) ? 4'd5 : v[7:4];
        s1  = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
        return {m10, m1, s10, s1};
    endfunction

    // One-second BCD decrement with borrow ripple; callers never pass 0000.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] m10, m1, s10, s1;
        {m10, m1, s10, s1} = v;
        if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
        end else begin
            s1 = 4'd9;
            if (s10 != 4'd0) begin
                s10 = s10 - 4'd1;
            end else begin
                s10 = 4'd5;
                if (m1 != 4'd0) begin
                    m1 = m1 - 4'd1;
                end else begin
                    m1  = 4'd9;
                    m10 = m10 - 4'd1;
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    assign w_load_val = sanitise(num_in);
    assign w_dec_val  = bcd_dec(r_num);
    assign w_tick     = (r_state == S_RUN) && (r_presc == c_presc_max);

    // Next-state logic. Priority: load, then tick, then push_c.
    always_comb begin
        w_state_nxt = r_state;
        w_num_nxt   = r_num;
        w_presc_nxt = r_presc;
        w_done_nxt  = 1'b0;

        if (load) begin
            w_num_nxt   = w_load_val;
            w_presc_nxt = '0;
            w_state_nxt = (w_load_val != 16'h0000) ? S_PAUSED : S_IDLE;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_tick) begin
                        w_presc_nxt = '0;
                        if (r_num != 16'h0000) begin
                            w_num_nxt = w_dec_val;
                            if (w_dec_val == 16'h0000) begin
                                // Reaching zero wins over a coincident press.
                                w_state_nxt = S_ALARM;
                                w_done_nxt  = 1'b1;
                            end else if (push_c) begin
                                w_state_nxt = S_PAUSED;
                            end
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        // The pausing cycle still counts as a run cycle.
                        w_presc_nxt = r_presc + c_presc_one;
                        if (push_c) begin
                            w_state_nxt = S_PAUSED;
                        end
                    end
                end
                S_PAUSED: begin
                    if (push_c) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_ALARM: begin
                    if (push_c) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_num     <= 16'h0000;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_num     <= w_num_nxt;
            r_presc   <= w_presc_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_done    <= w_done_nxt;
            r_alarm   <= (w_state_nxt == S_ALARM);
        end
    end

    assign num     = r_num;
    assign running = r_running;
    assign done    = r_done;
    assign alarm   = r_alarm;

endmodule

`default_nettype wire

// File: tb/tb_service_1_countdown.sv
// ============================================================================
// Module   : tb_service_1_countdown
// Purpose  : Directed, table-driven bench for service_1_countdown with a
//            one-second tick of four clock cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_service_1_countdown;

    localparam int TICK_DIV = 4;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] num_in;
    logic        push_c;
    logic [15:0] num;
    logic        running;
    logic        done;
    logic        alarm;

    int checks;
    int failures;

    typedef struct {
        logic        ld;
        logic [15:0] ni;
        logic        pc;
        logic [15:0] e_num;
        logic        e_run;
        logic        e_done;
        logic        e_alarm;
    } vec_t;

    vec_t vecs[$];

    service_1_countdown #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .num_in  (num_in),
        .push_c  (push_c),
        .num     (num),
        .running (running),
        .done    (done),
        .alarm   (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic ld, input logic [15:0] ni, input logic pc,
                       input logic [15:0] en, input logic er, input logic ed,
                       input logic ea);
        vec_t v;
        v.ld = ld; v.ni = ni; v.pc = pc;
        v.e_num = en; v.e_run = er; v.e_done = ed; v.e_alarm = ea;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] en,
                         input logic er, input logic ed, input logic ea);
        checks++;
        if (num !== en || running !== er || done !== ed || alarm !== ea) begin
            failures++;
            $display("FAIL %s: got num=%h run=%b done=%b alarm=%b, want num=%h run=%b done=%b alarm=%b",
                     name, num, running, done, alarm, en, er, ed, ea);
        end
    endtask

    // Drive one cycle of inputs, clock it, then sample just after the edge.
    task automatic step(input logic ld, input logic [15:0] ni, input logic pc);
        load   = ld;
        num_in = ni;
        push_c = pc;
        @(posedge clk);
        #1;
        load   = 1'b0;
        num_in = 16'h0000;
        push_c = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        load     = 1'b0;
        num_in   = 16'h0000;
        push_c   = 1'b0;
        reset    = 1'b1;

        // ---- vector table ------------------------------------------------
        // Load 01:02, run, single decrement then minute borrow.
        add(1, 16'h0102, 0, 16'h0102, 0, 0, 0);
        add(0, 16'h0000, 1, 16'h0102, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0102, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0102, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0102, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0101, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0101, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0101, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0101, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0100, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0100, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0100, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0100, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0059, 1, 0, 0);
        // Load 00:02 over a running count, run to alarm, acknowledge.
        add(1, 16'h0002, 0, 16'h0002, 0, 0, 0);
        add(0, 16'h0000, 1, 16'h0002, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0002, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0002, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0002, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0001, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0001, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0001, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0001, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0000, 0, 1, 1);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 1);
        add(0, 16'h0000, 1, 16'h0000, 0, 0, 0);
        add(0, 16'h0000, 1, 16'h0000, 0, 0, 0);
        // Sanitising, load+push collision in RUN, zero load to IDLE.
        add(1, 16'hAB7C, 0, 16'h9959, 0, 0, 0);
        add(0, 16'h0000, 1, 16'h9959, 1, 0, 0);
        add(1, 16'h0030, 1, 16'h0030, 0, 0, 0);
        add(0, 16'h0000, 1, 16'h0030, 1, 0, 0);
        add(1, 16'h0000, 0, 16'h0000, 0, 0, 0);
        add(0, 16'h0000, 1, 16'h0000, 0, 0, 0);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 0);
        // Tick coinciding with a press: decrement and pause.
        add(1, 16'h0011, 0, 16'h0011, 0, 0, 0);
        add(0, 16'h0000, 1, 16'h0011, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0011, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0011, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0011, 1, 0, 0);
        add(0, 16'h0000, 1, 16'h0010, 0, 0, 0);
        add(0, 16'h0000, 0, 16'h0010, 0, 0, 0);
        // Tick reaching zero coinciding with a press: alarm wins.
        add(1, 16'h0001, 0, 16'h0001, 0, 0, 0);
        add(0, 16'h0000, 1, 16'h0001, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0001, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0001, 1, 0, 0);
        add(0, 16'h0000, 0, 16'h0001, 1, 0, 0);
        add(0, 16'h0000, 1, 16'h0000, 0, 1, 1);
        add(0, 16'h0000, 0, 16'h0000, 0, 0, 1);
        add(0, 16'h0000, 1, 16'h0000, 0, 0, 0);

        // ---- reset state -------------------------------------------------
        #2;
        check("reset_async", 16'h0000, 0, 0, 0);
        @(posedge clk);
        #1;
        check("reset_held", 16'h0000, 0, 0, 0);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // ---- table -------------------------------------------------------
        foreach (vecs[i]) begin
            step(vecs[i].ld, vecs[i].ni, vecs[i].pc);
            check($sformatf("vec%0d", i), vecs[i].e_num, vecs[i].e_run,
                  vecs[i].e_done, vecs[i].e_alarm);
        end

        // ---- pause mid-second preserves the partial second ---------------
        step(1, 16'h0010, 0);
        step(0, 16'h0000, 1);           // start, prescaler 0
        step(0, 16'h0000, 0);           // prescaler 1
        step(0, 16'h0000, 1);           // pause, prescaler 2
        check("pause_enter", 16'h0010, 0, 0, 0);
        for (int k = 0; k < 20; k++) step(0, 16'h0000, 0);
        check("pause_hold", 16'h0010, 0, 0, 0);
        step(0, 16'h0000, 1);           // resume
        check("resume_run", 16'h0010, 1, 0, 0);
        step(0, 16'h0000, 0);
        check("resume_partial", 16'h0010, 1, 0, 0);
        step(0, 16'h0000, 0);
        check("resume_dec", 16'h0009, 1, 0, 0);

        // ---- asynchronous reset while running ---------------------------
        step(1, 16'h0045, 0);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 0);
        check("pre_reset_run", 16'h0045, 1, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check("reset_midrun", 16'h0000, 0, 0, 0);
        #1;
        reset = 1'b0;
        step(0, 16'h0000, 1);
        check("post_reset_push", 16'h0000, 0, 0, 0);
        step(0, 16'h0000, 0);
        check("post_reset_idle", 16'h0000, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
